fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: fetch_req  input  1  control unit's start-fetch pulse.
REQ-004 SHALL have port: pc_in  input  64  address to fetch.
REQ-005 SHALL have port: flush  input  1  abort the current fetch.
REQ-006 SHALL have port: imem_req  output  1  instruction memory request.
REQ-007 SHALL have port: imem_addr  output  64  instruction memory address.
REQ-008 SHALL have port: imem_ack  input  1  memory data valid, one-cycle pulse.
REQ-009 SHALL have port: imem_rdata  input  32  memory read data.
REQ-010 SHALL have port: instruction_out  output  32  instruction register (IR) to the control unit.
REQ-011 SHALL have port: pc_out  output  64  address of the instruction held in IR.
REQ-012 SHALL have port: instr_valid  output  1  one-cycle pulse when IR is updated.
REQ-013 SHALL have port: fetch_busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port: misalign  output  1  one-cycle pulse when pc_in[1:0] is nonzero.

Function
REQ-015 SHALL use the states IDLE, WAIT and DISCARD.
REQ-016 IDLE with fetch_req=1, flush=0 and pc_in[1:0]=0 SHALL latch pc_in and go to WAIT.
- imem_req SHALL assert on the next cycle.
- imem_addr SHALL equal the latched pc.
REQ-017 IDLE with fetch_req=1, flush=0 and pc_in[1:0]!=0 SHALL take the misalign path.
- misalign SHALL pulse on the next cycle.
- No memory request SHALL be issued, IR and pc_out SHALL be unchanged, and the state SHALL remain IDLE.
REQ-018 In WAIT, imem_req and imem_addr SHALL be held stable until the imem_ack cycle; a request is never retracted.
REQ-019 imem_ack in WAIT SHALL complete the fetch.
- IR SHALL take imem_rdata and pc_out SHALL take the latched pc at that edge.
- instr_valid SHALL be high for exactly the following cycle.
- The state SHALL return to IDLE, with imem_req low from that cycle.
REQ-020 Minimum latency SHALL be 2 cycles from fetch_req to instr_valid when imem_ack comes on the first imem_req cycle.
REQ-021 flush=1 in WAIT without imem_ack SHALL go to DISCARD.
- imem_req SHALL stay high until imem_ack.
- On imem_ack, the data SHALL be dropped: no IR update, no instr_valid, return to IDLE.
REQ-022 flush and imem_ack in the same WAIT cycle SHALL be treated as a flush: data dropped, return to IDLE.
REQ-023 flush=1 in IDLE SHALL override a simultaneous fetch_req; no fetch starts.
REQ-024 fetch_req while fetch_busy=1 SHALL be ignored, with no queueing.
REQ-025 imem_ack in IDLE SHALL be ignored.
REQ-026 IR and pc_out SHALL hold their value between valid fetches.

Reset
REQ-027 reset=0 SHALL immediately force all of the following, regardless of clk:
- state IDLE
- imem_req=0, imem_addr=0
- instruction_out=32'h00000013 (NOP), pc_out=0
- instr_valid=0, misalign=0, fetch_busy=0, timeout=0 where present
REQ-028 Reset asserted during WAIT or DISCARD SHALL abandon the transaction; a later imem_ack SHALL be ignored.

Configuration
REQ-029 Macro FETCH_TIMEOUT_EN defined SHALL add output timeout (1 bit) and a 4-bit wait counter.
- The counter SHALL clear on entering WAIT or DISCARD and increment each cycle without imem_ack.
- When it reaches 15 without ack: imem_req SHALL drop on the next cycle and timeout SHALL pulse 1 cycle.
- The state SHALL return to IDLE with IR unchanged.
REQ-030 Macro FETCH_TIMEOUT_EN undefined SHALL omit the port and counter; WAIT SHALL wait indefinitely.

Verification
REQ-031 Zero-wait fetch:
- Stimulus: pc_in=0x100, fetch_req pulse; imem_ack on the first imem_req cycle with rdata=0x00500093.
- Response: instr_valid 2 cycles after fetch_req; instruction_out=0x00500093; pc_out=0x100.
REQ-032 Three-wait fetch:
- Stimulus: ack 3 cycles after req, with fetch_req pulsed again during WAIT.
- Response: imem_addr stable throughout; second request ignored; exactly one instr_valid.
REQ-033 Misalign:
- Stimulus: pc_in=0x102 with fetch_req.
- Response: misalign pulse; imem_req never asserted; IR retains its prior value.
REQ-034 Flush mid-fetch:
- Stimulus: flush 1 cycle into WAIT, ack 2 cycles later with rdata=0xDEADBEEF.
- Response: no instr_valid; IR unchanged; fetch_busy low after ack.
REQ-035 Reset mid-fetch:
- Stimulus: reset=0 during WAIT, then release.
- Response: imem_req=0 immediately; instruction_out=0x00000013; a stray ack after release is ignored.
REQ-036 With FETCH_TIMEOUT_EN:
- Stimulus: no ack for 16 cycles.
- Response: timeout pulse; imem_req deasserted; state IDLE; a new fetch_req is accepted.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM (IDLE/WAIT/DISCARD)
// Ports: clk, reset (async active-low); fetch_req/pc_in/flush from control;
// imem_req/imem_addr/imem_ack/imem_rdata to instruction memory;
// instruction_out/pc_out/instr_valid/fetch_busy/misalign back to control.
// Define FETCH_TIMEOUT_EN to add a 4-bit wait counter and a timeout pulse output.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [63:0] pc_in,
  input  logic        flush,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [63:0] pc_out,
  output logic        instr_valid,
  output logic        fetch_busy,
`ifdef FETCH_TIMEOUT_EN
  output logic        timeout,
`endif
  output logic        misalign
);
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
  state_t state, state_nx;
  logic idle_go, start, bad, load, expire;
`ifdef FETCH_TIMEOUT_EN
  logic [3:0] cnt;
`endif
  assign imem_req   = state != IDLE;
  assign fetch_busy = state != IDLE;
  always_comb begin
    idle_go = state == IDLE && fetch_req && !flush;
    start   = idle_go && pc_in[1:0] == 2'b00;
    bad     = idle_go && pc_in[1:0] != 2'b00;
    // a flush in the ack cycle wins, so the returning word is dropped
    load    = state == WAIT && imem_ack && !flush;
`ifdef FETCH_TIMEOUT_EN
    expire  = state != IDLE && !imem_ack && cnt == 4'hf;
`else
    expire  = 1'b0;
`endif
    state_nx = start ? WAIT :
               (state == IDLE || imem_ack || expire) ? IDLE :
               (flush || state == DISCARD) ? DISCARD : WAIT;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_addr       <= '0;
      instruction_out <= 32'h0000_0013;
      pc_out          <= '0;
      instr_valid     <= 1'b0;
      misalign        <= 1'b0;
    end else begin
      instr_valid <= load;
      misalign    <= bad;
      if (start) imem_addr <= pc_in;
      if (load) begin
        instruction_out <= imem_rdata;
        pc_out          <= imem_addr;
      end
    end
  end
`ifdef FETCH_TIMEOUT_EN
  // restarts on every state change, so entering WAIT or DISCARD begins at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= (state_nx != state || state == IDLE) ? 4'd0 : cnt + 4'd1;
      timeout <= expire;
    end
  end
`endif
endmodule
